// File: rtl/hdmi_pkg.sv
// rtl/hdmi_pkg.sv - shared TMDS constants, scheduler state type and bit-split helpers
package hdmi_pkg;

    // The four TMDS control tokens, indexed by {C1,C0}.
    localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

    // One 10-bit word is sent as five DDR bit pairs.
    localparam int PHASES = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } sched_state_t;

    function automatic logic [9:0] ctrl_token(input logic [1:0] c1c0);
        case (c1c0)
            2'b00:   return CTRL_TOKEN_00;
            2'b01:   return CTRL_TOKEN_01;
            2'b10:   return CTRL_TOKEN_10;
            default: return CTRL_TOKEN_11;
        endcase
    endfunction

    // Bits for the DDR high half: b0 goes out first, then b2, b4, b6, b8.
    function automatic logic [4:0] even_bits(input logic [9:0] w);
        return {w[8], w[6], w[4], w[2], w[0]};
    endfunction

    // Bits for the DDR low half: b1, b3, b5, b7, b9.
    function automatic logic [4:0] odd_bits(input logic [9:0] w);
        return {w[9], w[7], w[5], w[3], w[1]};
    endfunction

endpackage

// File: rtl/tmds_word_sched_if.sv
// rtl/tmds_word_sched_if.sv - valid/ready word stream from the TMDS encoder
interface tmds_word_sched_if;

    logic [9:0] word_in;
    logic       word_valid;
    logic       word_ready;

    modport master (
        output word_in,
        output word_valid,
        input  word_ready
    );

    modport slave (
        input  word_in,
        input  word_valid,
        output word_ready
    );

endinterface

// File: rtl/tmds_word_fifo.sv
// rtl/tmds_word_fifo.sv - small synchronous word FIFO with registered occupancy
module tmds_word_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [LW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Flags come straight from the registered count so they never glitch on inputs.
    assign full    = (count == LW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage has no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; depth is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tmds_word_sched.sv
// rtl/tmds_word_sched.sv - word FIFO, 5-phase load sequencer and DDR bit-pair splitter
module tmds_word_sched
    import hdmi_pkg::*;
#(
    parameter logic [9:0] IDLE_WORD   = ctrl_token(2'b00),
    parameter int         FIFO_DEPTH  = 4,
    parameter int         PRIME_LEVEL = 2,
    parameter int         UCNT_W      = 16,
    localparam int        LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk_5x,
    input  logic                  sys_rst,
    input  logic                  en,
    tmds_word_sched_if.slave      word_if,
    output logic                  ser_rise,
    output logic                  ser_fall,
    output logic                  load,
    output logic                  underrun,
    output logic [UCNT_W-1:0]     underrun_cnt,
    output logic [LVL_W-1:0]      level
);

    sched_state_t state;
    logic [2:0]   ph;
    logic [4:0]   rs;
    logic [4:0]   fs;
    logic         load_cycle;
    logic         push;
    logic         pop;
    logic         starve;
    logic         fifo_full;
    logic         fifo_empty;
    logic [9:0]   fifo_head;
    logic [9:0]   next_word;

    // Last phase of the frame is where the next word is chosen.
    assign load_cycle = (ph == 3'(PHASES - 1));

    // Ready depends only on registered occupancy, never on word_valid.
    assign word_if.word_ready = !fifo_full;
    assign push               = word_if.word_valid && !fifo_full;

    // A pop only sees words already stored, so a same-edge push into an empty FIFO still starves.
    assign pop       = load_cycle && (state == ST_RUN) && !fifo_empty;
    assign starve    = load_cycle && (state == ST_RUN) && fifo_empty;
    assign next_word = pop ? fifo_head : IDLE_WORD;

    assign ser_rise = rs[0];
    assign ser_fall = fs[0];

    tmds_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (10)
    ) u_fifo (
        .clk       (clk_5x),
        .rst       (sys_rst),
        .push      (push),
        .push_data (word_if.word_in),
        .pop       (pop),
        .head      (fifo_head),
        .count     (level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Free-running 0..4 phase counter; keeps running in every state.
    always_ff @(posedge clk_5x) begin
        if (sys_rst) begin
            ph <= '0;
        end else if (load_cycle) begin
            ph <= '0;
        end else begin
            ph <= ph + 3'd1;
        end
    end

    // Stream FSM: disable always wins, priming waits for enough buffered words.
    always_ff @(posedge clk_5x) begin
        if (sys_rst) begin
            state <= ST_IDLE;
        end else if (!en) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  state <= ST_PRIME;
                ST_PRIME: begin
                    if (level >= LVL_W'(PRIME_LEVEL)) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN:   state <= ST_RUN;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // Shift registers load a fresh word at the end of phase 4 and shift one pair per cycle otherwise.
    always_ff @(posedge clk_5x) begin
        if (sys_rst) begin
            rs       <= even_bits(IDLE_WORD);
            fs       <= odd_bits(IDLE_WORD);
            load     <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (load_cycle) begin
                rs <= even_bits(next_word);
                fs <= odd_bits(next_word);
            end else begin
                rs <= {1'b0, rs[4:1]};
                fs <= {1'b0, fs[4:1]};
            end
            load     <= load_cycle;
            underrun <= starve;
        end
    end

    // Starvation counter sticks at all-ones rather than wrapping.
    always_ff @(posedge clk_5x) begin
        if (sys_rst) begin
            underrun_cnt <= '0;
        end else if (starve && (underrun_cnt != '1)) begin
            underrun_cnt <= underrun_cnt + UCNT_W'(1);
        end
    end

endmodule

// File: tb/tb_tmds_word_sched.sv
// tb/tb_tmds_word_sched.sv - directed self-checking bench for tmds_word_sched
module tb_tmds_word_sched;

    localparam logic [9:0] IDLE = 10'b1101010100;

    logic       clk_5x = 1'b0;
    logic       sys_rst;
    logic       en;
    logic       ser_rise;
    logic       ser_fall;
    logic       load;
    logic       underrun;
    logic [3:0] underrun_cnt;
    logic [2:0] level;

    int total = 0;
    int bad   = 0;
    int tph   = 0;

    logic [9:0] t3w [8];
    logic       t3u [8];
    int         t3c [8];
    logic [9:0] t3p [5];
    logic [9:0] t4  [5];

    tmds_word_sched_if bus ();

    tmds_word_sched #(
        .IDLE_WORD   (IDLE),
        .FIFO_DEPTH  (4),
        .PRIME_LEVEL (2),
        .UCNT_W      (4)
    ) dut (
        .clk_5x       (clk_5x),
        .sys_rst      (sys_rst),
        .en           (en),
        .word_if      (bus),
        .ser_rise     (ser_rise),
        .ser_fall     (ser_fall),
        .load         (load),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt),
        .level        (level)
    );

    always #4 clk_5x = ~clk_5x;

    task automatic step;
        @(posedge clk_5x);
        tph = sys_rst ? 0 : ((tph == 4) ? 0 : tph + 1);
        @(negedge clk_5x);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_pair(input string tag, input logic [9:0] w, input int k);
        check(tag, {30'b0, ser_fall, ser_rise}, {30'b0, w[2*k+1], w[2*k]});
    endtask

    task automatic check_word(input string tag, input logic [9:0] w, input logic exp_u);
        check({tag, "_load"}, load, 1);
        check({tag, "_underrun"}, underrun, exp_u);
        check_pair({tag, "_pair"}, w, 0);
        for (int k = 1; k < 5; k++) begin
            step();
            check_pair({tag, "_pair"}, w, k);
            check({tag, "_noload"}, load, 0);
        end
    endtask

    initial begin
        t3p = '{10'h0F0, 10'h30C, 10'h1E3, 10'h2B4, 10'h05A};
        t3w = '{IDLE, 10'h0F0, 10'h30C, 10'h1E3, 10'h2B4, IDLE, 10'h05A, IDLE};
        t3u = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        t3c = '{1, 1, 1, 1, 1, 2, 2, 3};
        t4  = '{10'h3E1, 10'h11C, 10'h2D2, 10'h0B7, 10'h3FF};

        sys_rst        = 1'b1;
        en             = 1'b0;
        bus.word_valid = 1'b0;
        bus.word_in    = '0;
        @(negedge clk_5x);
        step();
        step();

        // reset state
        check("rst_pair", {30'b0, ser_fall, ser_rise}, 0);
        check("rst_load", load, 0);
        check("rst_underrun", underrun, 0);
        check("rst_cnt", underrun_cnt, 0);
        check("rst_level", level, 0);
        check("rst_ready", bus.word_ready, 1);
        sys_rst = 1'b0;

        // disabled: idle token repeats, load every 5 cycles
        for (int i = 0; i < 20; i++) begin
            step();
            check_pair("idle_pair", IDLE, tph);
            check("idle_load", load, (tph == 0));
            check("idle_underrun", underrun, 0);
        end

        // prime with two words, then run them out
        en             = 1'b1;
        bus.word_valid = 1'b1;
        bus.word_in    = 10'h3FF;
        step();
        bus.word_in    = 10'h155;
        step();
        bus.word_valid = 1'b0;
        check("prime_level", level, 2);
        step();
        step();
        check("prime_hold_level", level, 2);
        step();
        check("run_level_after_pop", level, 1);
        check_word("run_3ff", 10'h3FF, 1'b0);
        step();
        check_word("run_155", 10'h155, 1'b0);
        step();
        check("starve_load", load, 1);
        check("starve_underrun", underrun, 1);
        check("starve_cnt", underrun_cnt, 1);
        check_pair("starve_pair", IDLE, 0);

        // source at one word per 6 cycles; last push lands on a decision edge
        for (int c = 0; c < 35; c++) begin
            bus.word_valid = ((c % 6) == 0) && (c <= 24);
            if ((c % 6) == 0 && c <= 24) begin
                bus.word_in = t3p[c/6];
            end
            step();
            if (c + 1 >= 5) begin
                check_pair("slow_pair", t3w[(c+1)/5], (c + 1) % 5);
                if ((c + 1) % 5 == 0) begin
                    check("slow_load", load, 1);
                    check("slow_underrun", underrun, t3u[(c+1)/5]);
                    check("slow_cnt", underrun_cnt, t3c[(c+1)/5]);
                end
            end
        end
        bus.word_valid = 1'b0;

        // fill FIFO while idle; fifth push dropped
        en = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            check("fill_ready", bus.word_ready, (i < 4));
            bus.word_valid = 1'b1;
            bus.word_in    = t4[i];
            step();
        end
        bus.word_valid = 1'b0;
        check("full_level", level, 4);
        check("full_ready", bus.word_ready, 0);
        en = 1'b1;
        step();
        step();
        step();
        step();
        for (int i = 0; i < 4; i++) begin
            check_word("full_drain", t4[i], 1'b0);
            step();
        end
        check("drain_underrun", underrun, 1);
        check("drain_cnt", underrun_cnt, 4);

        // long starvation saturates the 4-bit counter
        for (int f = 0; f < 20; f++) begin
            repeat (5) step();
            check("sat_underrun", underrun, 1);
        end
        check("sat_cnt", underrun_cnt, 15);

        // mid-word reset discards FIFO and restarts the phase
        bus.word_valid = 1'b1;
        bus.word_in    = 10'h155;
        step();
        bus.word_valid = 1'b0;
        check("pre_rst_level", level, 1);
        step();
        sys_rst = 1'b1;
        step();
        sys_rst = 1'b0;
        check("mid_rst_pair", {30'b0, ser_fall, ser_rise}, 0);
        check("mid_rst_load", load, 0);
        check("mid_rst_underrun", underrun, 0);
        check("mid_rst_cnt", underrun_cnt, 0);
        check("mid_rst_level", level, 0);
        check("mid_rst_ready", bus.word_ready, 1);
        for (int i = 1; i <= 5; i++) begin
            step();
            check("post_rst_load", load, (i == 5));
            check_pair("post_rst_pair", IDLE, i % 5);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
